// File: rtl/motor_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_ctrl
// Brief    : Multi-channel H-bridge PWM controller with soft duty ramping,
//            period-aligned duty updates and a reversal dead-time interlock.
// Revision : 1.0
// ============================================================================
module motor_pwm_ctrl #(
    parameter int NCH       = 2,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 200,
    parameter int PRESC     = 2,
    parameter int RAMP_STEP = 8,
    parameter int DEAD_PER  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_l,
    input  logic                 enable_i,
    input  logic [3*NCH-1:0]     speed_i,
    input  logic [NCH-1:0]       fwd_i,
    input  logic [NCH-1:0]       rev_i,
    output logic [NCH-1:0]       pwm_o,
    output logic [NCH-1:0]       dir_a_o,
    output logic [NCH-1:0]       dir_b_o,
    output logic [CNT_W*NCH-1:0] duty_o,
    output logic [NCH-1:0]       busy_o
);

    localparam int PS_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int DC_W = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;

    localparam logic [PS_W-1:0]  c_presc_max = PS_W'(PRESC - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_step      = CNT_W'(RAMP_STEP);
    localparam logic [DC_W-1:0]  c_dead_max  = DC_W'(DEAD_PER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] f_tgt(input logic [2:0] k);
        return CNT_W'((int'(k) * PERIOD) / 7);
    endfunction

    // Step toward the target by at most one ramp step, never past it.
    function automatic logic [CNT_W-1:0] f_ramp(input logic [CNT_W-1:0] cur,
                                                input logic [CNT_W-1:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) > c_step) ? cur + c_step : tgt;
        else if (cur > tgt)
            return ((cur - tgt) > c_step) ? cur - c_step : tgt;
        else
            return cur;
    endfunction

    logic [PS_W-1:0]  r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic             w_bnd;

    assign w_tick = (r_presc == c_presc_max);
    assign w_bnd  = w_tick && (r_cnt == c_cnt_max);

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (!enable_i) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [2:0]       w_speed;
        logic             w_fwd;
        logic             w_rev;
        logic             w_coast;
        logic             w_cmd_dir;
        logic [CNT_W-1:0] w_tgt;
        logic [CNT_W-1:0] w_eff;
        logic [CNT_W-1:0] w_next;

        state_t           r_state;
        logic             r_dir_q;
        logic             r_pend_q;
        logic [CNT_W-1:0] r_duty;
        logic [DC_W-1:0]  r_dead;
        logic             r_pwm;
        logic             r_dir_a;
        logic             r_dir_b;

        assign w_speed   = speed_i[3*n +: 3];
        assign w_fwd     = fwd_i[n] & ~rev_i[n];
        assign w_rev     = rev_i[n] & ~fwd_i[n];
        assign w_coast   = ~(w_fwd | w_rev);
        assign w_cmd_dir = w_rev;
        assign w_tgt     = f_tgt(w_speed);
        assign w_eff     = (r_state == ST_RUN) ? w_tgt : '0;
        assign w_next    = f_ramp(r_duty, w_eff);

        always_ff @(posedge clk_i or negedge reset_l) begin
            if (!reset_l) begin
                r_state  <= ST_IDLE;
                r_dir_q  <= 1'b0;
                r_pend_q <= 1'b0;
                r_duty   <= '0;
                r_dead   <= '0;
                r_pwm    <= 1'b0;
                r_dir_a  <= 1'b0;
                r_dir_b  <= 1'b0;
            end else if (!enable_i || w_coast) begin
                r_state <= ST_IDLE;
                r_duty  <= '0;
                r_dead  <= '0;
                r_pwm   <= 1'b0;
                r_dir_a <= 1'b0;
                r_dir_b <= 1'b0;
            end else begin
                r_pwm <= (r_cnt < r_duty);
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RUN;
                        r_dir_q <= w_cmd_dir;
                        r_dir_a <= ~w_cmd_dir;
                        r_dir_b <= w_cmd_dir;
                    end
                    ST_RUN: begin
                        if (w_bnd)
                            r_duty <= w_next;
                        if (w_cmd_dir != r_dir_q) begin
                            r_state  <= ST_STOP;
                            r_pend_q <= w_cmd_dir;
                        end
                    end
                    ST_STOP: begin
                        if (w_bnd)
                            r_duty <= w_next;
                        // A return to the running direction cancels the reversal.
                        if (w_cmd_dir == r_dir_q) begin
                            r_state <= ST_RUN;
                        end else if (w_bnd && (w_next == '0)) begin
                            r_state <= ST_DEAD;
                            r_dead  <= '0;
                            r_dir_a <= 1'b0;
                            r_dir_b <= 1'b0;
                        end
                    end
                    ST_DEAD: begin
                        r_pend_q <= w_cmd_dir;
                        if (w_bnd) begin
                            if (r_dead == c_dead_max) begin
                                r_state <= ST_RUN;
                                r_dead  <= '0;
                                r_dir_q <= r_pend_q;
                                r_dir_a <= ~r_pend_q;
                                r_dir_b <= r_pend_q;
                            end else begin
                                r_dead <= r_dead + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign pwm_o[n]                  = r_pwm;
        assign dir_a_o[n]                = r_dir_a;
        assign dir_b_o[n]                = r_dir_b;
        assign duty_o[n*CNT_W +: CNT_W]  = r_duty;
        assign busy_o[n] = (r_state == ST_STOP) || (r_state == ST_DEAD) ||
                           ((r_state == ST_RUN) && (r_duty != w_tgt));
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_pwm_ctrl
// Brief    : Directed self-checking bench for motor_pwm_ctrl at default params.
// Revision : 1.0
// ============================================================================
module tb_motor_pwm_ctrl;

    logic        clk_i;
    logic        reset_l;
    logic        enable_i;
    logic [5:0]  speed_i;
    logic [1:0]  fwd_i;
    logic [1:0]  rev_i;
    logic [1:0]  pwm_o;
    logic [1:0]  dir_a_o;
    logic [1:0]  dir_b_o;
    logic [15:0] duty_o;
    logic [1:0]  busy_o;

    int checks   = 0;
    int failures = 0;
    int inv_viol = 0;

    motor_pwm_ctrl dut (
        .clk_i    (clk_i),
        .reset_l  (reset_l),
        .enable_i (enable_i),
        .speed_i  (speed_i),
        .fwd_i    (fwd_i),
        .rev_i    (rev_i),
        .pwm_o    (pwm_o),
        .dir_a_o  (dir_a_o),
        .dir_b_o  (dir_b_o),
        .duty_o   (duty_o),
        .busy_o   (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; also watch the bridge interlock.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (|(dir_a_o & dir_b_o))
            inv_viol++;
    endtask

    function automatic logic [7:0] duty(input int ch);
        return duty_o[ch*8 +: 8];
    endfunction

    task automatic wait_duty(input int ch, output int cyc);
        logic [7:0] prev;
        prev = duty(ch);
        cyc  = 0;
        do begin
            step();
            cyc++;
        end while (duty(ch) == prev && cyc < 1000);
        checks++;
        assert (duty(ch) !== prev) else begin
            failures++;
            $error("FAIL wait_duty_ch%0d observed=%0d expected=change", ch, prev);
        end
    endtask

    int  cyc;
    int  h0;
    int  h1;
    int  viol;
    int  exp_d;
    logic p1;

    initial begin
        reset_l  = 1'b0;
        enable_i = 1'b1;
        speed_i  = '0;
        fwd_i    = '0;
        rev_i    = '0;
        step(); step(); step();
        chk("rst_pwm",   32'(pwm_o),   0);
        chk("rst_dir_a", 32'(dir_a_o), 0);
        chk("rst_duty",  32'(duty_o),  0);
        reset_l = 1'b1;
        step();

        // Ramp ch0 toward full speed, ch1 toward 57, then reset asynchronously mid-ramp.
        speed_i[2:0] = 3'd7;
        speed_i[5:3] = 3'd2;
        fwd_i        = 2'b11;
        for (int i = 0; i < 12; i++) wait_duty(0, cyc);
        chk("pre_reset_duty0", 32'(duty(0)), 96);
        chk("pre_reset_dir_a", 32'(dir_a_o), 3);
        #2 reset_l = 1'b0;
        #1;
        chk("async_rst_pwm",   32'(pwm_o),   0);
        chk("async_rst_dir_a", 32'(dir_a_o), 0);
        chk("async_rst_dir_b", 32'(dir_b_o), 0);
        chk("async_rst_duty",  32'(duty_o),  0);
        chk("async_rst_busy",  32'(busy_o),  0);
        fwd_i = '0;
        step(); step();
        reset_l = 1'b1;
        step(); step();
        chk("post_rst_duty0", 32'(duty(0)), 0);
        chk("post_rst_dir_a", 32'(dir_a_o), 0);
        chk("post_rst_busy",  32'(busy_o),  0);

        // Full ramp 8..200 on ch0, one step per 400-cycle period.
        fwd_i = 2'b11;
        step();
        chk("run_dir_a", 32'(dir_a_o), 3);
        chk("run_dir_b", 32'(dir_b_o), 0);
        chk("run_busy0", 32'(busy_o[0]), 1);
        for (int i = 0; i < 25; i++) begin
            wait_duty(0, cyc);
            chk($sformatf("ramp_up_duty0_%0d", i), 32'(duty(0)), 32'(8 * (i + 1)));
            if (i > 0) chk($sformatf("ramp_up_period_%0d", i), 32'(cyc), 400);
        end
        chk("full_busy0", 32'(busy_o[0]), 0);
        chk("steady_duty1", 32'(duty(1)), 57);
        chk("steady_busy1", 32'(busy_o[1]), 0);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            h0 += int'(pwm_o[0]);
            h1 += int'(pwm_o[1]);
        end
        chk("pwm0_high_full", 32'(h0), 400);
        chk("pwm1_high_57",   32'(h1), 114);

        // Period-aligned window on ch1; a mid-period speed change must not alter it.
        p1  = pwm_o[1];
        cyc = 0;
        do begin
            p1 = pwm_o[1];
            step();
            cyc++;
        end while (!(pwm_o[1] && !p1) && cyc < 1000);
        chk("pwm1_rise_found", 32'(pwm_o[1] && !p1), 1);
        h1 = 1;
        for (int j = 1; j < 400; j++) begin
            if (j == 200) speed_i[5:3] = 3'd3;
            step();
            h1 += int'(pwm_o[1]);
        end
        chk("pwm1_high_speedchg", 32'(h1), 114);
        chk("duty1_after_chg", 32'(duty(1)), 65);
        wait_duty(1, cyc); chk("duty1_73", 32'(duty(1)), 73);
        wait_duty(1, cyc); chk("duty1_81", 32'(duty(1)), 81);
        wait_duty(1, cyc); chk("duty1_85", 32'(duty(1)), 85);
        chk("duty1_85_busy", 32'(busy_o[1]), 0);

        // Coast ch1 with both requests; ch0 must keep running.
        rev_i[1] = 1'b1;
        step();
        chk("coast1_dir_a", 32'(dir_a_o[1]), 0);
        chk("coast1_dir_b", 32'(dir_b_o[1]), 0);
        chk("coast1_pwm",   32'(pwm_o[1]),   0);
        chk("coast1_duty",  32'(duty(1)),    0);
        chk("coast1_busy",  32'(busy_o[1]),  0);
        chk("coast1_ch0_duty", 32'(duty(0)), 200);
        chk("coast1_ch0_dir",  32'(dir_a_o[0]), 1);
        rev_i[1] = 1'b0;

        // Slow ch0 to speed 4, then reverse through ramp-down and dead time.
        speed_i[2:0] = 3'd4;
        for (int i = 0; i < 11; i++) begin
            wait_duty(0, cyc);
            exp_d = 200 - 8 * (i + 1);
            if (exp_d < 114) exp_d = 114;
            chk($sformatf("ramp_down_%0d", i), 32'(duty(0)), 32'(exp_d));
        end
        chk("at114_busy0", 32'(busy_o[0]), 0);
        fwd_i[0] = 1'b0;
        rev_i[0] = 1'b1;
        step();
        chk("stop_dir_a", 32'(dir_a_o[0]), 1);
        chk("stop_busy",  32'(busy_o[0]),  1);
        for (int i = 0; i < 15; i++) begin
            wait_duty(0, cyc);
            exp_d = (i < 14) ? 106 - 8 * i : 0;
            chk($sformatf("stop_duty_%0d", i), 32'(duty(0)), 32'(exp_d));
            if (i < 14) chk($sformatf("stop_dir_hold_%0d", i), 32'(dir_a_o[0]), 1);
        end
        chk("dead_dir_a", 32'(dir_a_o[0]), 0);
        chk("dead_dir_b", 32'(dir_b_o[0]), 0);
        chk("dead_busy",  32'(busy_o[0]),  1);
        cyc  = 0;
        viol = 0;
        do begin
            step();
            cyc++;
            if (pwm_o[0] || dir_a_o[0]) viol++;
        end while (!dir_b_o[0] && cyc < 1000);
        chk("dead_time_cycles", 32'(cyc), 800);
        chk("dead_time_quiet",  32'(viol), 0);
        wait_duty(0, cyc);
        chk("rev_ramp_8",     32'(duty(0)), 8);
        chk("rev_ramp_delay", 32'(cyc), 400);
        wait_duty(0, cyc);
        chk("rev_ramp_16", 32'(duty(0)), 16);
        chk("rev_dir_b",   32'(dir_b_o[0]), 1);

        // Global disable while both channels run, then re-enable with commands held.
        enable_i = 1'b0;
        step();
        chk("dis_pwm",   32'(pwm_o),   0);
        chk("dis_dir_a", 32'(dir_a_o), 0);
        chk("dis_dir_b", 32'(dir_b_o), 0);
        chk("dis_duty",  32'(duty_o),  0);
        chk("dis_busy",  32'(busy_o),  0);
        enable_i = 1'b1;
        step();
        chk("reen_dir_a", 32'(dir_a_o), 2);
        chk("reen_dir_b", 32'(dir_b_o), 1);
        chk("reen_duty",  32'(duty_o),  0);
        wait_duty(0, cyc);
        chk("reen_duty0", 32'(duty(0)), 8);
        chk("reen_delay", 32'(cyc), 399);
        chk("reen_duty1", 32'(duty(1)), 8);

        chk("dir_interlock", 32'(inv_viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
Multi-channel, self-contained motor PWM controller. It replaces the fixed single-channel register-sequencing controller with direct per-channel PWM generation from a shared timebase. Each channel provides a 3-bit speed select, duty soft-ramping, glitch-free duty update at period boundaries, and a direction interlock (ramp-down plus dead time) on H-bridge reversal. It sits between board switches/upper logic and the H-bridge driver pins.

Parameters:
NCH, 2, number of independent motor channels
CNT_W, 8, period/duty counter width; PERIOD < 2**CNT_W
PERIOD, 200, PWM period in timebase ticks
PRESC, 2, clk_i cycles per timebase tick (>=1)
RAMP_STEP, 8, max duty change per PWM period
DEAD_PER, 2, whole PWM periods with bridge off during reversal (>=1)

Ports:
clk_i  in  1  system clock
reset_l  in  1  asynchronous, active-low reset
enable_i  in  1  global enable; low forces all channels idle
speed_i  in  3*NCH  per-channel speed code k (ch n at [3n+2:3n])
fwd_i  in  NCH  per-channel forward request
rev_i  in  NCH  per-channel reverse request
pwm_o  out  NCH  PWM output, registered
dir_a_o  out  NCH  bridge leg A enable (forward)
dir_b_o  out  NCH  bridge leg B enable (reverse)
duty_o  out  CNT_W*NCH  current applied duty per channel
busy_o  out  NCH  channel ramping, stopping or in dead time

Behaviour:
- Reset (reset_l=0, async): all outputs 0, prescaler/period counters 0, all channels IDLE, duty_cur=0.
- Timebase (shared):
  - Prescaler counts 0..PRESC-1; tick when it equals PRESC-1.
  - Period counter cnt advances 0..PERIOD-1 per tick, then wraps to 0.
  - Boundary event = tick with cnt==PERIOD-1. Period is PERIOD*PRESC clk_i cycles (400 at defaults).
- enable_i=0: counters held at 0; every channel goes IDLE synchronously, duty_cur=0, pwm_o=0, dir=00.
- Target duty:
  - tgt(k) = (k*PERIOD)/7, integer division, constant table; defaults give 0,28,57,85,114,142,171,200.
  - k=7 gives duty=PERIOD, i.e. 100% on.
- pwm_o[n] <= (cnt < duty_cur[n]); one clk_i latency after cnt changes. duty_cur=0 means constant low.
- Duty update (glitch-free): duty_cur changes only on a boundary event (except forced clears).
  - Update rule: duty_cur moves toward the effective target by min(RAMP_STEP, |target-duty_cur|); no overshoot.
  - Speed changes mid-period take effect at the next boundary.
- Command decode: FWD = fwd&!rev; REV = rev&!fwd; COAST = both or neither.
- Per-channel FSM (dir_q = latched running direction, pend_q = pending direction):
  - IDLE: dir=00, duty_cur=0. FWD/REV -> RUN; dir_q set; dir outputs assert next clk; ramp-up begins at next boundary.
  - RUN: dir_a_o=(dir_q==FWD), dir_b_o=(dir_q==REV); effective target = tgt(k).
    - COAST -> IDLE immediately: duty_cur=0, dir=00 next clk.
    - Opposite command -> STOPPING with pend_q latched.
  - STOPPING: dir held at dir_q; effective target 0, ramping down.
    - At a boundary where duty_cur reaches 0 -> DEAD.
    - Command back to dir_q -> RUN; ramp resumes toward tgt(k).
    - COAST -> IDLE.
  - DEAD: dir=00, pwm_o=0; counts DEAD_PER boundaries.
    - Then -> RUN with dir_q=pend_q; ramp-up from 0.
    - COAST -> IDLE. Command equal to the old dir_q updates pend_q; dead time still completes.
- Simultaneous events:
  - COAST beats everything.
  - A boundary coinciding with a state change uses the new state's rules on the next boundary.
- Invariant: dir_a_o & dir_b_o is never 1 on any channel.
- busy_o = (state==STOPPING | state==DEAD | (state==RUN & duty_cur!=tgt(k))).
- duty_o = duty_cur (registered).

Test Plan:
- Reset mid-ramp (ch0 at duty 96), assert reset_l low async -> all outputs 0 within the same cycle with no clock; after release, ch0 IDLE, duty_o=0.
- ch0 fwd=1, speed=7, defaults -> dir_a_o=1 next clk; duty_o goes 8,16,...,200 at successive boundaries (25 periods); pwm_o then constantly 1; busy_o drops when duty_o=200.
- ch0 running fwd at speed 4 (duty 114); switch to rev -> duty ramps down 106..2,0; then 2 periods with dir=00 and pwm_o=0; then dir_b_o=1 and ramp back up toward 114. dir_a_o&dir_b_o never 1.
- ch1 at speed 3 (duty 85), set both fwd and rev -> next clk dir=00, pwm_o=0, duty_o=0, IDLE; ch0 unaffected.
- Steady duty 57, PRESC=2: pwm_o high exactly 114 clk_i per 400-cycle period; speed change mid-period leaves the current period unchanged.
- enable_i=0 while both channels run -> all pwm_o/dir 0 and duty 0 next clk; re-enable with fwd held -> ramp restarts from 0.
